clk_period_meter: RTL
=====================

# clk_period_meter

Measures a slow clock or tick signal, such as a clock divider output, in units of the system clock. It synchronises the input and detects its rising edges. For each complete cycle of the input it reports the period and the high time. It also reports whether consecutive periods agree (lock) and whether the input has stopped (timeout). It sits on the receiving side of divided-clock nets and is used for self-checking divider settings and for status display.

## Interface
- CNT_W, 26, width of the period, high-time and run counters
- TIMEOUT, 50_000_000, cycles without a rising edge before the input is declared lost; must be < 2^CNT_W
- TOL, 0, maximum absolute difference between consecutive periods that still counts as a match
- LOCK_N, 4, number of consecutive matches needed to assert Locked; must be >= 1

- Clk  in  1  system clock, all logic on its rising edge
- Rst  in  1  synchronous, active-low reset
- SigIn  in  1  measured signal, asynchronous to Clk
- Period  out  CNT_W  last measured period, in Clk cycles between rising edges
- HighTime  out  CNT_W  Clk cycles SigIn was high within the last measured period
- Valid  out  1  one-cycle pulse; Period and HighTime updated this cycle
- Locked  out  1  level; consecutive periods stable within TOL
- Timeout  out  1  level; no rising edge for TIMEOUT cycles

## Operation
- Synchroniser: S1 <= SigIn, S2 <= S1, S3 <= S2.
  - Rise = S2 & ~S3.
  - "High" means S2 == 1.
- RunCnt:
  - loads 1 on Rise;
  - otherwise increments, saturating at TIMEOUT.
- HighRun:
  - loads 1 on Rise;
  - otherwise increments while S2 is high and holds while S2 is low, saturating at TIMEOUT.
- States:
  - IDLE:
    - Rise -> MEAS, with no Valid.
    - RunCnt == TIMEOUT with no Rise -> LOST.
  - MEAS:
    - Rise -> stay in MEAS. Period <= RunCnt, HighTime <= HighRun, Valid pulses, and the lock update runs.
    - RunCnt == TIMEOUT with no Rise -> LOST.
  - LOST:
    - Timeout = 1.
    - Rise -> MEAS, with no Valid, because the interrupted period is discarded.
- Lock update on each Valid:
  - Match means |RunCnt − Period(old)| <= TOL, computed without wrap (compare larger minus smaller).
  - On a match, LockRun increments, saturating at LOCK_N. Locked <= 1 when the new LockRun == LOCK_N.
  - On a mismatch, LockRun <= 0 and Locked <= 0.
- Entering LOST clears LockRun and Locked.
- Period and HighTime hold their last values in LOST and IDLE.
- If Rise occurs in the same cycle that RunCnt == TIMEOUT, Rise wins.
  - In MEAS this is a valid measurement with Period = TIMEOUT; the state stays MEAS.
  - In IDLE or LOST the state goes to MEAS.
- Reset (Rst == 0 at a Clk edge), at any time including mid-measurement:
  - S1–S3 = 0, RunCnt = 0, HighRun = 0, LockRun = 0;
  - state IDLE;
  - Period = 0, HighTime = 0, Valid = 0, Locked = 0, Timeout = 0.
- If SigIn is high at reset release, that produces a Rise. Because the state is IDLE, it only starts measurement.

## Timing
- A SigIn transition first sampled into S1 at edge k is seen in S2 after edge k+1. Rise is evaluated in the cycle after edge k+1.
- Valid, Period, HighTime and Locked are registered at edge k+2. Latency from SigIn sample to Valid is therefore 3 edges.
- For a stable input with rising edges N cycles apart:
  - Valid pulses exactly every N cycles.
  - Period = N and HighTime = number of S2-high cycles.
- Valid is never high for two consecutive cycles unless N == 1; N == 1 cannot occur through the synchroniser, so the minimum is N = 2.
- Timeout asserts the cycle after RunCnt reaches TIMEOUT. It deasserts 1 cycle after the next Rise.
- With the defaults, the first Valid after reset always mismatches, because the stored Period is 0. Locked rises on the (LOCK_N+1)-th Valid of a stable input.

## Test plan
- Reset: drive Rst = 0 for 3 cycles with SigIn toggling -> all outputs 0, and no Valid for 3 cycles after release.
- Square input, 2 cycles high and 2 low (divide value 1) -> Valid every 4 cycles; Period = 4, HighTime = 2; Locked = 1 on the 5th Valid (LOCK_N = 4).
- Period change from 4 to 6 cycles while Locked (TOL = 0) -> next Valid shows Period = 6 and Locked = 0; Locked returns after 4 further stable Valids.
- TIMEOUT = 20, hold SigIn low after a lock -> Timeout = 1 and Locked = 0 about 21 cycles after the last Rise. Restart the input -> the first Rise gives no Valid, and Valid resumes on the next Rise.
- Rise coincident with RunCnt == TIMEOUT (period exactly 20, TIMEOUT = 20) -> Valid with Period = 20, and Timeout stays 0.
- Rst pulsed low mid-period while Locked -> outputs clear on the next edge. After release, the first Rise gives no Valid and the second gives a correct Period.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow input in i_clk cycles,
// with lock (consecutive periods agree within TOL) and timeout (input stopped).
//
// Ports:
//   i_clk        system clock, all logic on its rising edge
//   i_rst_n      synchronous active-low reset
//   i_sig_in     measured signal, asynchronous to i_clk
//   o_period     last measured period (i_clk cycles between rising edges)
//   o_high_time  cycles the synchronised input was high within that period
//   o_valid      one-cycle pulse when o_period/o_high_time update
//   o_locked     consecutive periods stable within TOL
//   o_timeout    no rising edge for TIMEOUT cycles
module clk_period_meter #(
   parameter int CNT_W   = 26,
   parameter int TIMEOUT = 50_000_000,
   parameter int TOL     = 0,
   parameter int LOCK_N  = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_sig_in,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high_time,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_timeout
);

   localparam int LR_W = $clog2(LOCK_N + 1);

   localparam logic [CNT_W-1:0] C_TMO   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] C_TOL   = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
   localparam logic [LR_W-1:0]  C_LOCKN = LR_W'(LOCK_N);
   localparam logic [LR_W-1:0]  C_LONE  = LR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEAS,
      S_LOST
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic r_s1;
   logic r_s2;
   logic r_s3;

   logic [CNT_W-1:0] r_run_cnt;
   logic [CNT_W-1:0] r_high_run;
   logic [LR_W-1:0]  r_lock_run;

   logic             w_rise;
   logic             w_run_sat;
   logic             w_high_sat;
   logic             w_meas;
   logic             w_lose;
   logic [CNT_W-1:0] w_diff;
   logic             w_match;
   logic [LR_W-1:0]  w_lock_inc;

   assign w_rise     = r_s2 & ~r_s3;
   assign w_run_sat  = (r_run_cnt == C_TMO);
   assign w_high_sat = (r_high_run == C_TMO);

   // Distance between the new and the stored period, without wrap.
   assign w_diff = (r_run_cnt >= o_period) ?
                   (r_run_cnt - o_period) :
                   (o_period - r_run_cnt);

   assign w_match = (w_diff <= C_TOL);

   assign w_lock_inc = (r_lock_run == C_LOCKN) ?
                       r_lock_run :
                       (r_lock_run + C_LONE);

   // Three-flop synchroniser; S2 is the usable level, S3 its history.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_sig_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // Cycles since the last rise, and high cycles within them.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_run_cnt  <= '0;
         r_high_run <= '0;
      end else begin
         if (w_rise) begin
            r_run_cnt <= C_ONE;
         end else if (!w_run_sat) begin
            r_run_cnt <= r_run_cnt + C_ONE;
         end

         if (w_rise) begin
            r_high_run <= C_ONE;
         end else if (r_s2 && !w_high_sat) begin
            r_high_run <= r_high_run + C_ONE;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A rise always beats a coincident timeout. Only a rise that closes a
   // period started by an earlier rise in MEAS is a measurement.
   always_comb begin
      w_state_nxt = r_state;
      w_meas      = 1'b0;
      w_lose      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_rise) begin
               w_state_nxt = S_MEAS;
            end else if (w_run_sat) begin
               w_state_nxt = S_LOST;
               w_lose      = 1'b1;
            end
         end
         S_MEAS: begin
            if (w_rise) begin
               w_state_nxt = S_MEAS;
               w_meas      = 1'b1;
            end else if (w_run_sat) begin
               w_state_nxt = S_LOST;
               w_lose      = 1'b1;
            end
         end
         S_LOST: begin
            if (w_rise) begin
               w_state_nxt = S_MEAS;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_period    <= '0;
         o_high_time <= '0;
         o_valid     <= 1'b0;
         o_locked    <= 1'b0;
         o_timeout   <= 1'b0;
         r_lock_run  <= '0;
      end else begin
         o_valid   <= w_meas;
         o_timeout <= (w_state_nxt == S_LOST);
         if (w_meas) begin
            o_period    <= r_run_cnt;
            o_high_time <= r_high_run;
            if (w_match) begin
               r_lock_run <= w_lock_inc;
               o_locked   <= (w_lock_inc == C_LOCKN);
            end else begin
               r_lock_run <= '0;
               o_locked   <= 1'b0;
            end
         end else if (w_lose) begin
            r_lock_run <= '0;
            o_locked   <= 1'b0;
         end
      end
   end

endmodule
